// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: one operand bit per cycle.
// Fixed BITS+2 cycle latency from accepted start to finished.
module muldiv_seq #(
  parameter int BITS = 8
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic              in_mode,
  input  logic              in_signed,
  input  logic [BITS-1:0]   in_a,
  input  logic [BITS-1:0]   in_b,
  output logic              out_busy,
  output logic              out_finished,
  output logic [2*BITS-1:0] out_prod,
  output logic [BITS-1:0]   out_quot,
  output logic [BITS-1:0]   out_rem,
  output logic              out_dbz
);

  typedef enum logic [2:0] {
    IDLE, PREP, RUN, FIX, DONE
  } state_t;

  localparam int CW = $clog2(BITS);

  state_t r_state, w_next;

  logic [CW-1:0]     r_cnt;
  logic [BITS-1:0]   r_a, r_b, r_m;
  logic              r_mode, r_sgn;
  logic              r_neg_q, r_neg_r;
  logic [2*BITS-1:0] r_p;
  logic [2*BITS-1:0] r_prod;
  logic [BITS-1:0]   r_quot, r_rem;
  logic              r_dbz;

  logic              w_accept, w_last;
  logic              w_sa, w_sb, w_ge;
  logic [BITS-1:0]   w_ma, w_mb, w_sub;
  logic [BITS-1:0]   w_q, w_r;
  logic [BITS:0]     w_sum, w_sh;
  logic [2*BITS-1:0] w_step, w_pm;

  assign w_accept = in_start &
    ((r_state == IDLE) | (r_state == DONE));
  assign w_last = (r_cnt == CW'(BITS-1));

  assign w_sa = r_sgn & r_a[BITS-1];
  assign w_sb = r_sgn & r_b[BITS-1];
  assign w_ma = w_sa ? -r_a : r_a;
  assign w_mb = w_sb ? -r_b : r_b;

  // r_p: mul = {acc, multiplier} shifting right,
  // div = {rem, dividend/quot} shifting left
  assign w_sum = {1'b0, r_p[2*BITS-1:BITS]}
    + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_sh  = {r_p[2*BITS-1:BITS], r_p[BITS-1]};
  assign w_ge  = w_sh[BITS] | (w_sh[BITS-1:0] >= r_m);
  assign w_sub = w_sh[BITS-1:0] - r_m;

  assign w_step = r_mode
    ? {(w_ge ? w_sub : w_sh[BITS-1:0]),
       r_p[BITS-2:0], w_ge}
    : {w_sum, r_p[BITS-1:1]};

  assign w_pm = r_neg_q ? -r_p : r_p;
  assign w_q  = r_neg_q ? -r_p[BITS-1:0]
                        : r_p[BITS-1:0];
  assign w_r  = r_neg_r ? -r_p[2*BITS-1:BITS]
                        : r_p[2*BITS-1:BITS];

  always_ff @(posedge in_clk) begin
    if (!in_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = PREP;
      PREP:    w_next = RUN;
      RUN:     if (w_last) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    if (w_accept) w_next = PREP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_mode  <= 1'b0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_p     <= '0;
      r_prod  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_mode <= in_mode;
            r_sgn  <= in_signed;
          end
        end
        PREP: begin
          r_cnt   <= '0;
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_m     <= r_mode ? w_mb : w_ma;
          r_p     <= {{BITS{1'b0}},
                      (r_mode ? w_ma : w_mb)};
        end
        RUN: begin
          r_p   <= w_step;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          if (r_mode) begin
            r_prod <= '0;
            r_dbz  <= (r_m == '0);
            r_quot <= (r_m == '0) ? '1 : w_q;
            r_rem  <= (r_m == '0) ? r_a : w_r;
          end else begin
            r_prod <= w_pm;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_busy = (r_state == PREP) |
    (r_state == RUN) | (r_state == FIX);
  assign out_finished = (r_state == DONE);
  assign out_prod = r_prod;
  assign out_quot = r_quot;
  assign out_rem  = r_rem;
  assign out_dbz  = r_dbz;

endmodule
